pattern_seq_ctrl: RTL

Controller that drives the 2-bit pattern select input of the VGA pattern generator. It is clocked in the 25.2 MHz pixel clock domain. It takes a raw push-button (manual step) and a mode switch (auto-cycle), and derives frame boundaries from the generator's vsync output. Every pattern change is applied only at the start of a frame, so no frame is ever drawn with mixed patterns.

---
 rtl/pattern_seq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/pattern_seq_ctrl.sv
// Pattern select controller for the VGA pattern generator.
// Manual steps come from a debounced push-button and auto-cycling from a frame counter; both take effect only on a vsync falling edge.
module pattern_seq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 252000,
  parameter int unsigned AUTO_FRAMES     = 120,
  parameter int unsigned NUM_PATTERNS    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_btn,
  input  logic       i_auto,
  input  logic       i_vs,
  output logic [1:0] o_pattern_select,
  output logic       o_pending,
  output logic [7:0] o_frame_cnt
);

  localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  AF_LAST  = 8'(AUTO_FRAMES - 1);
  localparam logic [1:0]  PAT_LAST = 2'(NUM_PATTERNS - 1);

  // Handshake: none. btn_press is a 1-cycle pulse; a press is held in PEND
  // (visible on o_pending) until the next frame_tick consumes it.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic        btn_s1, btn_s2, auto_s1, auto_s2;
  logic        btn_db, btn_db_d;
  logic [19:0] db_cnt;
  logic        vs_d;
  logic        btn_press, frame_tick, auto_wrap, advance;
  logic [7:0]  frame_cnt_nxt;
  logic [1:0]  pattern_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
      vs_d    <= 1'b1;
    end else begin
      btn_s1  <= i_btn;
      btn_s2  <= btn_s1;
      auto_s1 <= i_auto;
      auto_s2 <= auto_s1;
      vs_d    <= i_vs;
    end
  end

  // The counter tracks how long the synchronized button has disagreed with the accepted level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  assign btn_press  = btn_db & ~btn_db_d;
  assign frame_tick = vs_d & ~i_vs;
  assign o_pending  = (state == PEND);

  always_comb begin
    state_nxt     = state;
    auto_wrap     = 1'b0;
    frame_cnt_nxt = o_frame_cnt;
    pattern_nxt   = o_pattern_select;
    case (state)
      IDLE: if (btn_press) state_nxt = PEND;
      PEND: if (frame_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!auto_s2) begin
      frame_cnt_nxt = 8'd0;
    end else if (frame_tick) begin
      if (o_frame_cnt == AF_LAST) begin
        frame_cnt_nxt = 8'd0;
        auto_wrap     = 1'b1;
      end else begin
        frame_cnt_nxt = o_frame_cnt + 8'd1;
      end
    end
    // A pending step and an auto wrap on the same tick merge into one advance.
    advance = ((state == PEND) && frame_tick) || auto_wrap;
    if (advance) begin
      pattern_nxt = (o_pattern_select == PAT_LAST) ? 2'd0 : o_pattern_select + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      o_frame_cnt      <= 8'd0;
      o_pattern_select <= 2'd0;
    end else begin
      state            <= state_nxt;
      o_frame_cnt      <= frame_cnt_nxt;
      o_pattern_select <= pattern_nxt;
    end
  end

endmodule
